// File: rtl/alu_design.sv
// ============================================================================
// Module   : alu_design
// Brief    : Registered, clock-enabled integer ALU with a two-stage multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_design #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic                   MODE,
  input  logic [1:0]             INP_VALID,
  input  logic [CMD_WIDTH-1:0]   CMD,
  input  logic [WIDTH-1:0]       OPA,
  input  logic [WIDTH-1:0]       OPB,
  input  logic                   CIN,
  output logic [2*WIDTH-1:0]     RES,
  output logic                   COUT,
  output logic                   OFLOW,
  output logic                   G,
  output logic                   E,
  output logic                   L,
  output logic                   ERR
);

  localparam int                c_RW      = 2 * WIDTH;
  localparam int                c_SH      = $clog2(WIDTH);
  localparam logic [c_RW-1:0]   c_ONE_X   = c_RW'(1);
  localparam logic [WIDTH-1:0]  c_ONE     = WIDTH'(1);
  localparam logic [c_SH:0]     c_WIDTH_X = (c_SH + 1)'(WIDTH);
  localparam logic [1:0]        c_NEED_AB = 2'b11;
  localparam logic [1:0]        c_NEED_A  = 2'b01;
  localparam logic [1:0]        c_NEED_B  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_MUL_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_RW-1:0]  w_a_x, w_b_x, w_shl_x, w_mul_prod, r_mul_prod;
  logic [c_RW-1:0]  w_res;
  logic [WIDTH-1:0] w_log;
  logic [WIDTH-1:0] w_rol, w_ror;
  logic [c_SH-1:0]  w_amt;
  logic [c_SH:0]    w_amt_inv;
  logic             w_rot_bad;
  logic [1:0]       w_need;
  logic             w_illegal, w_op_missing, w_rot, w_is_mul;
  logic             w_cout, w_oflow, w_g, w_e, w_l, w_err;
  logic             w_load, w_cap, w_load_mul;

  assign w_a_x      = {{WIDTH{1'b0}}, OPA};
  assign w_b_x      = {{WIDTH{1'b0}}, OPB};
  assign w_shl_x    = {{WIDTH{1'b0}}, OPA << 1};
  assign w_mul_prod = (CMD == CMD_WIDTH'(9)) ? (w_a_x + c_ONE_X) * (w_b_x + c_ONE_X)
                                             : w_shl_x * w_b_x;

  // Rotates built from two opposing shifts; a shift by WIDTH yields zero.
  assign w_amt     = OPB[c_SH-1:0];
  assign w_amt_inv = c_WIDTH_X - {1'b0, w_amt};
  assign w_rol     = (OPA << w_amt) | (OPA >> w_amt_inv);
  assign w_ror     = (OPA >> w_amt) | (OPA << w_amt_inv);
  assign w_rot_bad = |OPB[WIDTH-1:c_SH];

  always_comb begin
    w_res     = '0;
    w_log     = '0;
    w_cout    = 1'b0;
    w_oflow   = 1'b0;
    w_g       = 1'b0;
    w_e       = 1'b0;
    w_l       = 1'b0;
    w_need    = c_NEED_AB;
    w_illegal = 1'b0;
    w_rot     = 1'b0;
    w_is_mul  = 1'b0;
    if (MODE) begin
      case (CMD)
        CMD_WIDTH'(0): begin
          w_res  = w_a_x + w_b_x;
          w_cout = w_res[WIDTH];
        end
        CMD_WIDTH'(1): begin
          w_res   = {{WIDTH{1'b0}}, OPA - OPB};
          w_oflow = (OPA < OPB);
        end
        CMD_WIDTH'(2): begin
          w_res  = w_a_x + w_b_x + {{(c_RW-1){1'b0}}, CIN};
          w_cout = w_res[WIDTH];
        end
        CMD_WIDTH'(3): begin
          w_res   = {{WIDTH{1'b0}}, OPA - OPB - {{(WIDTH-1){1'b0}}, CIN}};
          w_oflow = ({1'b0, OPA} < ({1'b0, OPB} + {{WIDTH{1'b0}}, CIN}));
        end
        CMD_WIDTH'(4): begin
          w_need = c_NEED_A;
          w_res  = w_a_x + c_ONE_X;
          w_cout = w_res[WIDTH];
        end
        CMD_WIDTH'(5): begin
          w_need  = c_NEED_A;
          w_res   = {{WIDTH{1'b0}}, OPA - c_ONE};
          w_oflow = (OPA == '0);
        end
        CMD_WIDTH'(6): begin
          w_need = c_NEED_B;
          w_res  = w_b_x + c_ONE_X;
          w_cout = w_res[WIDTH];
        end
        CMD_WIDTH'(7): begin
          w_need  = c_NEED_B;
          w_res   = {{WIDTH{1'b0}}, OPB - c_ONE};
          w_oflow = (OPB == '0);
        end
        CMD_WIDTH'(8): begin
          w_g = (OPA > OPB);
          w_e = (OPA == OPB);
          w_l = (OPA < OPB);
        end
        CMD_WIDTH'(9), CMD_WIDTH'(10): w_is_mul = 1'b1;
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (CMD)
        CMD_WIDTH'(0):  w_log = OPA & OPB;
        CMD_WIDTH'(1):  w_log = ~(OPA & OPB);
        CMD_WIDTH'(2):  w_log = OPA | OPB;
        CMD_WIDTH'(3):  w_log = ~(OPA | OPB);
        CMD_WIDTH'(4):  w_log = OPA ^ OPB;
        CMD_WIDTH'(5):  w_log = ~(OPA ^ OPB);
        CMD_WIDTH'(6):  begin w_need = c_NEED_A; w_log = ~OPA;     end
        CMD_WIDTH'(7):  begin w_need = c_NEED_B; w_log = ~OPB;     end
        CMD_WIDTH'(8):  begin w_need = c_NEED_A; w_log = OPA >> 1; end
        CMD_WIDTH'(9):  begin w_need = c_NEED_A; w_log = OPA << 1; end
        CMD_WIDTH'(10): begin w_need = c_NEED_B; w_log = OPB >> 1; end
        CMD_WIDTH'(11): begin w_need = c_NEED_B; w_log = OPB << 1; end
        CMD_WIDTH'(12): begin w_rot = 1'b1; w_log = w_rol; end
        CMD_WIDTH'(13): begin w_rot = 1'b1; w_log = w_ror; end
        default:        w_illegal = 1'b1;
      endcase
      w_res = {{WIDTH{1'b0}}, w_log};
    end

    w_op_missing = ((w_need & ~INP_VALID) != 2'b00);
    w_err        = w_illegal | w_op_missing | (w_rot & w_rot_bad);
    // A bad rotate amount still drives the rotated value; other errors clear everything.
    if (w_illegal || w_op_missing) begin
      w_res    = '0;
      w_cout   = 1'b0;
      w_oflow  = 1'b0;
      w_g      = 1'b0;
      w_e      = 1'b0;
      w_l      = 1'b0;
      w_is_mul = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_load_mul  = 1'b0;
    if (CE) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            w_cap       = 1'b1;
            w_state_nxt = S_MUL_WAIT;
          end else begin
            w_load = 1'b1;
          end
        end
        S_MUL_WAIT: w_state_nxt = S_MUL_DONE;
        S_MUL_DONE: begin
          w_load_mul  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mul_prod <= '0;
    end else if (w_cap) begin
      r_mul_prod <= w_mul_prod;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES   <= '0;
      COUT  <= 1'b0;
      OFLOW <= 1'b0;
      G     <= 1'b0;
      E     <= 1'b0;
      L     <= 1'b0;
      ERR   <= 1'b0;
    end else if (w_load) begin
      RES   <= w_res;
      COUT  <= w_cout;
      OFLOW <= w_oflow;
      G     <= w_g;
      E     <= w_e;
      L     <= w_l;
      ERR   <= w_err;
    end else if (w_load_mul) begin
      RES   <= r_mul_prod;
      COUT  <= 1'b0;
      OFLOW <= 1'b0;
      G     <= 1'b0;
      E     <= 1'b0;
      L     <= 1'b0;
      ERR   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_design.sv
// ============================================================================
// Module   : tb_alu_design
// Brief    : Directed self-checking bench for alu_design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_design;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic        MODE;
  logic [1:0]  INP_VALID;
  logic [3:0]  CMD;
  logic [7:0]  OPA;
  logic [7:0]  OPB;
  logic        CIN;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;

  int checks   = 0;
  int failures = 0;

  alu_design #(.WIDTH(8), .CMD_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .INP_VALID(INP_VALID),
    .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flag vector order: {COUT, OFLOW, G, E, L, ERR}
  function automatic logic [5:0] flags();
    return {COUT, OFLOW, G, E, L, ERR};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    MODE = m; CMD = c; INP_VALID = v; OPA = a; OPB = b; CIN = ci;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; CE = 1'b0;
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    #3;
    chk("reset_res", RES, 16'h0000);
    chk("reset_flags", {10'b0, flags()}, 16'h0000);
    tick();
    RST = 1'b1; CE = 1'b1;

    drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0); tick();
    chk("add_res", RES, 16'h0100);
    chk("add_flags", {10'b0, flags()}, 16'b100000);

    drive(1'b1, 4'd1, 2'b11, 8'h05, 8'h07, 1'b0); tick();
    chk("sub_res", RES, 16'h00FE);
    chk("sub_flags", {10'b0, flags()}, 16'b010000);

    drive(1'b1, 4'd8, 2'b11, 8'h33, 8'h33, 1'b0); tick();
    chk("cmp_eq_res", RES, 16'h0000);
    chk("cmp_eq_flags", {10'b0, flags()}, 16'b000100);
    drive(1'b1, 4'd8, 2'b11, 8'h40, 8'h33, 1'b0); tick();
    chk("cmp_gt_flags", {10'b0, flags()}, 16'b001000);
    drive(1'b1, 4'd8, 2'b11, 8'h10, 8'h33, 1'b0); tick();
    chk("cmp_lt_flags", {10'b0, flags()}, 16'b000010);

    drive(1'b1, 4'd2, 2'b11, 8'hFF, 8'h00, 1'b1); tick();
    chk("addcin_res", RES, 16'h0100);
    chk("addcin_flags", {10'b0, flags()}, 16'b100000);

    drive(1'b1, 4'd3, 2'b11, 8'h05, 8'h05, 1'b1); tick();
    chk("subcin_res", RES, 16'h00FF);
    chk("subcin_flags", {10'b0, flags()}, 16'b010000);

    drive(1'b1, 4'd5, 2'b01, 8'h00, 8'h00, 1'b0); tick();
    chk("deca_res", RES, 16'h00FF);
    chk("deca_flags", {10'b0, flags()}, 16'b010000);

    drive(1'b1, 4'd6, 2'b10, 8'h00, 8'hFF, 1'b0); tick();
    chk("incb_cout", {15'b0, COUT}, 16'h0001);

    drive(1'b1, 4'd4, 2'b01, 8'h10, 8'h00, 1'b0); tick();
    chk("inca_res", RES, 16'h0011);
    chk("inca_flags", {10'b0, flags()}, 16'h0000);

    // Multiply: two holding edges, new command on the intermediate edge ignored
    drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0); tick();
    chk("mul_hold0", RES, 16'h0011);
    drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0); tick();
    chk("mul_hold1", RES, 16'h0011);
    tick();
    chk("mulinc_res", RES, 16'h000C);
    chk("mulinc_flags", {10'b0, flags()}, 16'h0000);
    tick();
    chk("after_mul_add", RES, 16'h0002);

    drive(1'b1, 4'd10, 2'b11, 8'h81, 8'h03, 1'b0); tick(); tick(); tick();
    chk("mulshl_res", RES, 16'h0006);

    drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0); tick();
    chk("rol_res", RES, 16'h0003);
    chk("rol_err", {15'b0, ERR}, 16'h0000);
    drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0); tick();
    chk("rol_bad_err", {15'b0, ERR}, 16'h0001);
    chk("rol_bad_res", RES, 16'h0003);
    drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0); tick();
    chk("ror_res", RES, 16'h00C0);

    drive(1'b0, 4'd4, 2'b11, 8'h0F, 8'hFF, 1'b0); tick();
    chk("xor_res", RES, 16'h00F0);

    drive(1'b0, 4'd0, 2'b01, 8'hFF, 8'hFF, 1'b0); tick();
    chk("and_missing_err", {15'b0, ERR}, 16'h0001);
    chk("and_missing_res", RES, 16'h0000);
    drive(1'b0, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0); tick();
    chk("illegal_err", {15'b0, ERR}, 16'h0001);
    chk("illegal_res", RES, 16'h0000);

    drive(1'b1, 4'd0, 2'b11, 8'h10, 8'h20, 1'b0); tick();
    chk("ce_load", RES, 16'h0030);
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd1, 2'b11, 8'(i), 8'hF0, 1'b1); tick();
      chk("ce_hold_res", RES, 16'h0030);
      chk("ce_hold_flags", {10'b0, flags()}, 16'h0000);
    end

    CE = 1'b1;
    drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0); tick();
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_res", RES, 16'h0000);
    chk("rst_mid_flags", {10'b0, flags()}, 16'h0000);
    tick();
    RST = 1'b1;
    drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0); tick();
    chk("post_rst_add", RES, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_design.md
Name: alu_design

Overview:
- Clocked, parameterised integer ALU. Registered outputs, clock-enabled, with per-operand input-valid qualification.
- Performs arithmetic (MODE=1) or logical/shift/rotate (MODE=0) operations selected by CMD.
- Drives a double-width result, carry/overflow flags, compare flags and an error flag.
- Sits behind the alu_inf interface as the datapath under test.

Parameters:
- WIDTH, 8, operand width in bits.
- CMD_WIDTH, 4, opcode width.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- CE  in  1  clock enable; 0 holds every output register.
- MODE  in  1  1 = arithmetic, 0 = logical.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- CMD  in  CMD_WIDTH  opcode.
- OPA  in  WIDTH  operand A.
- OPB  in  WIDTH  operand B.
- CIN  in  1  carry/borrow-in for ADD_CIN/SUB_CIN.
- RES  out  2*WIDTH  result.
- COUT  out  1  carry-out.
- OFLOW  out  1  borrow/underflow.
- G  out  1  OPA > OPB (CMP only).
- E  out  1  OPA == OPB (CMP only).
- L  out  1  OPA < OPB (CMP only).
- ERR  out  1  illegal command or operand missing.

Behaviour:
- Reset (RST=0, asynchronous): RES=0; COUT, OFLOW, G, E, L, ERR = 0; multiply pipeline cleared. A reset arriving mid-multiply aborts the multiply.
- Sampling: inputs are sampled on a rising edge with CE=1. Outputs for that sample update on the same edge, so they are visible one cycle after the inputs were presented.
- CE=0: all outputs hold; inputs are ignored.
- Flag defaults: every flag not defined for the current command is 0 in that result cycle.
- Operand requirements: two-operand commands need INP_VALID=11. *_A commands need bit0; *_B commands need bit1. If the requirement is not met: ERR=1, RES=0.
- Arithmetic commands (MODE=1):
  - 0 ADD: RES = A + B, WIDTH+1 bits. COUT = RES[WIDTH].
  - 1 SUB: RES = (A − B) mod 2^WIDTH. OFLOW = (A < B).
  - 2 ADD_CIN: as ADD, plus CIN.
  - 3 SUB_CIN: RES = (A − B − CIN) mod 2^WIDTH. OFLOW = (A < B + CIN).
  - 4 INC_A: A + 1, COUT on wrap.
  - 5 DEC_A: A − 1, OFLOW on A = 0.
  - 6 INC_B: B + 1, COUT on wrap.
  - 7 DEC_B: B − 1, OFLOW on B = 0.
  - 8 CMP: RES = 0; exactly one of G/E/L = 1.
  - 9 MUL_INC: RES = (A + 1) * (B + 1).
  - 10 MUL_SHL: RES = ((A << 1) mod 2^WIDTH) * B.
  - 11–15: illegal → ERR=1.
- Logical commands (MODE=0); results are WIDTH bits, zero-extended:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B (shift by one, zero fill).
  - 12 ROL_A_B: rotate A left by OPB[$clog2(WIDTH)-1:0].
  - 13 ROR_A_B: rotate A right by the same amount.
  - For 12/13, if any OPB bit above the shift-amount field is 1: ERR=1 and the rotated value is still driven on RES.
  - 14–15: illegal → ERR=1.
- Multiply timing (CMD 9/10 in MODE=1): latency is 2 sampled cycles. The result is registered on the second enabled edge after capture. The intermediate edge leaves outputs at their previous values, and any new command presented there is ignored.
- Simultaneous events: reset dominates CE. An error overrides the result (RES=0) except for the rotate case above.

Test Plan:
- Reset released, CE=1, MODE=1, CMD=0, INP_VALID=11, OPA=8'hFF, OPB=8'h01 → next cycle RES=16'h0100, COUT=1, ERR=0.
- MODE=1, CMD=1, OPA=8'h05, OPB=8'h07 → RES=16'h00FE, OFLOW=1. Then CMD=8, OPA=OPB=8'h33 → E=1, G=0, L=0, RES=0.
- MODE=1, CMD=9, OPA=8'h02, OPB=8'h03 → RES=16'h000C on the second cycle. The intermediate cycle keeps the previous RES.
- MODE=0, CMD=12, OPA=8'h81, OPB=8'h01 → RES=16'h0003, ERR=0. With OPB=8'h11 → ERR=1.
- MODE=0, CMD=0, INP_VALID=01 → ERR=1, RES=0. Then MODE=0, CMD=15 → ERR=1.
- Load a result, drop CE for 3 cycles while changing inputs → outputs unchanged. Assert RST=0 mid-multiply → all outputs 0 immediately.
